picosoc_memfabric: RTL

- Parametrised memory interconnect between the PicoRV32 native memory bus and the SoC targets.
- Replaces fixed decode with a registered address decoder that serves:
  - internal byte-writable RAM;
  - a program ROM port;
  - N_SLV iomem slave channels.
- Adds a per-access bus-timeout watchdog and error/status registers with a sticky bus-error interrupt.
- Sits directly under the CPU, between it and the progmem, uart and peripheral blocks.

---
 rtl/picosoc_pkg.sv | 24 ++
 rtl/picosoc_ram.sv | 31 +++
 rtl/picosoc_memfabric.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/picosoc_pkg.sv
// Shared types and address-map constants for the PicoSoC memory fabric.
// Contents: FSM state enum, access target enum, fixed STAT/ROM boundaries.
package picosoc_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [31:0] STAT_BASE = 32'h0200_0000;
  localparam logic [31:0] ROM_END   = 32'h0200_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  typedef enum logic [2:0] {
    TGT_RAM,
    TGT_ROM,
    TGT_STAT,
    TGT_SLV,
    TGT_UNMAPPED
  } tgt_e;

endpackage

// File: rtl/picosoc_ram.sv
// Byte-writable synchronous single-port RAM, 32-bit words.
// Ports: clk; i_en access enable; i_wstrb byte strobes (0 = read);
//        i_addr word address; i_wdata write data; o_rdata registered read data.
module picosoc_ram #(
  parameter int unsigned WORDS = 256,
  parameter int unsigned AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic [3:0]    i_wstrb,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [WORDS];
  logic [31:0] r_rdata;

  // Storage array carries no reset; read returns pre-write contents.
  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wstrb[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/picosoc_memfabric.sv
// PicoRV32 native-bus interconnect: registered decode to internal RAM,
// program ROM, STAT registers and N_SLV iomem slaves, with per-access
// watchdog and sticky bus-error interrupt.
// Ports: clk, reset (sync, active high); cpu_* CPU native bus;
//        rom_* program ROM port; slv_* broadcast slave channels with one-hot
//        valid; bus_err_irq sticky error interrupt.
module picosoc_memfabric
  import picosoc_pkg::*;
#(
  parameter int unsigned RAM_WORDS      = 256,
  parameter int unsigned N_SLV          = 4,
  parameter logic [31:0] SLV_BASE       = 32'h0300_0000,
  parameter logic [31:0] SLV_SPAN       = 32'h0001_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_valid,
  input  logic                  cpu_instr,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  input  logic [3:0]            cpu_wstrb,
  output logic                  cpu_ready,
  output logic [31:0]           cpu_rdata,
  output logic                  rom_valid,
  output logic [31:0]           rom_addr,
  input  logic                  rom_ready,
  input  logic [31:0]           rom_rdata,
  output logic [N_SLV-1:0]      slv_valid,
  output logic [31:0]           slv_addr,
  output logic [31:0]           slv_wdata,
  output logic [3:0]            slv_wstrb,
  input  logic [N_SLV-1:0]      slv_ready,
  input  logic [32*N_SLV-1:0]   slv_rdata,
  output logic                  bus_err_irq
);

  localparam int unsigned RAM_AW  = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned SLV_IW  = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam logic [31:0] RAM_END = 32'(4 * RAM_WORDS);

  state_e              r_state, w_state_n;
  tgt_e                r_target, w_target_n, w_dec_tgt;
  logic [SLV_IW-1:0]   r_idx, w_idx_n, w_dec_idx;
  logic                r_err, w_err_n, w_dec_err;
  logic [31:0]         r_addr, w_addr_n, r_wdata, w_wdata_n;
  logic [3:0]          r_wstrb, w_wstrb_n;
  logic [31:0]         r_cnt, w_cnt_n, w_cnt_inc;
  logic [31:0]         r_rdata, w_rdata_n;
  logic                r_cpu_ready, w_cpu_ready_n;
  logic [31:0]         r_cpu_rdata, w_cpu_rdata_n;
  logic                r_rom_valid, w_rom_valid_n;
  logic [31:0]         r_rom_addr, w_rom_addr_n;
  logic [N_SLV-1:0]    r_slv_valid, w_slv_valid_n;
  logic [31:0]         r_slv_addr, w_slv_addr_n, r_slv_wdata, w_slv_wdata_n;
  logic [3:0]          r_slv_wstrb, w_slv_wstrb_n;
  logic [31:0]         r_err_addr, w_err_addr_n;
  logic [15:0]         r_err_cnt, w_err_cnt_n;
  logic                r_irq, w_irq_n;
  logic                w_ram_en, w_fail, w_limit, w_tgt_ready;
  logic [31:0]         w_tgt_rdata, w_ram_rdata;
  logic [32:0]         w_slv_lo;
  logic                w_unused;

  assign w_unused = cpu_instr;

  picosoc_ram #(.WORDS(RAM_WORDS), .AW(RAM_AW)) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_wstrb (r_wstrb),
    .i_addr  (r_addr[RAM_AW+1:2]),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Address decode of the live CPU request; latched on IDLE -> ACCESS.
  always_comb begin
    w_dec_tgt = TGT_UNMAPPED;
    w_dec_idx = '0;
    w_slv_lo  = '0;
    for (int k = 0; k < int'(N_SLV); k++) begin
      w_slv_lo = {1'b0, SLV_BASE} + 33'(k) * {1'b0, SLV_SPAN};
      if (({1'b0, cpu_addr} >= w_slv_lo) &&
          ({1'b0, cpu_addr} < (w_slv_lo + {1'b0, SLV_SPAN}))) begin
        w_dec_tgt = TGT_SLV;
        w_dec_idx = SLV_IW'(k);
      end
    end
    if (cpu_addr < RAM_END)
      w_dec_tgt = TGT_RAM;
    else if (cpu_addr < ROM_END)
      w_dec_tgt = TGT_ROM;
    else if ((cpu_addr == STAT_BASE) || (cpu_addr == STAT_BASE + 32'd4))
      w_dec_tgt = TGT_STAT;
    w_dec_err = (w_dec_tgt == TGT_UNMAPPED) ||
                ((w_dec_tgt == TGT_ROM) && (cpu_wstrb != 4'd0));
  end

  // Next-state, watchdog and registered-output computation.
  always_comb begin
    w_state_n     = r_state;
    w_target_n    = r_target;
    w_idx_n       = r_idx;
    w_err_n       = r_err;
    w_addr_n      = r_addr;
    w_wdata_n     = r_wdata;
    w_wstrb_n     = r_wstrb;
    w_cnt_n       = r_cnt;
    w_rdata_n     = r_rdata;
    w_rom_valid_n = r_rom_valid;
    w_slv_valid_n = r_slv_valid;
    w_cpu_ready_n = 1'b0;
    w_cpu_rdata_n = r_cpu_rdata;
    w_err_addr_n  = r_err_addr;
    w_err_cnt_n   = r_err_cnt;
    w_irq_n       = r_irq;
    w_ram_en      = 1'b0;
    w_fail        = 1'b0;
    w_tgt_ready   = 1'b0;
    w_tgt_rdata   = '0;
    w_cnt_inc     = r_cnt + 32'd1;
    w_limit       = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == 32'(TIMEOUT_CYCLES));

    // Only the selected target's handshake is observed.
    if (r_target == TGT_ROM) begin
      w_tgt_ready = rom_ready;
      w_tgt_rdata = rom_rdata;
    end else if (r_target == TGT_SLV) begin
      w_tgt_ready = slv_ready[r_idx];
      w_tgt_rdata = slv_rdata[{r_idx, 5'b0} +: 32];
    end

    unique case (r_state)
      ST_IDLE: begin
        // cpu_ready high means the CPU still shows the finished request.
        if (cpu_valid && !r_cpu_ready) begin
          w_state_n     = ST_ACCESS;
          w_target_n    = w_dec_tgt;
          w_idx_n       = w_dec_idx;
          w_err_n       = w_dec_err;
          w_addr_n      = cpu_addr;
          w_wdata_n     = cpu_wdata;
          w_wstrb_n     = cpu_wstrb;
          w_cnt_n       = '0;
          w_rom_valid_n = (w_dec_tgt == TGT_ROM) && !w_dec_err;
          w_slv_valid_n = (w_dec_tgt == TGT_SLV) ? (N_SLV'(1) << w_dec_idx) : '0;
        end
      end
      ST_ACCESS: begin
        if (r_err) begin
          w_fail = 1'b1;
        end else begin
          case (r_target)
            TGT_RAM: begin
              w_ram_en  = 1'b1;
              w_state_n = ST_RESP;
            end
            TGT_STAT: begin
              w_state_n = ST_RESP;
              if (r_wstrb != 4'd0) begin
                w_err_addr_n = '0;
                w_err_cnt_n  = '0;
                w_irq_n      = 1'b0;
              end
            end
            TGT_ROM, TGT_SLV: begin
              // Ready sampled on the limit cycle still wins over timeout.
              if (w_tgt_ready) begin
                w_rdata_n     = w_tgt_rdata;
                w_rom_valid_n = 1'b0;
                w_slv_valid_n = '0;
                w_state_n     = ST_RESP;
              end else if (w_limit) begin
                w_fail = 1'b1;
              end else begin
                w_cnt_n = w_cnt_inc;
              end
            end
            default: w_fail = 1'b1;
          endcase
        end
        if (w_fail) begin
          w_state_n     = ST_RESP;
          w_err_n       = 1'b1;
          w_rom_valid_n = 1'b0;
          w_slv_valid_n = '0;
          w_err_addr_n  = r_addr;
          w_irq_n       = 1'b1;
          if (r_err_cnt != 16'hFFFF) w_err_cnt_n = r_err_cnt + 16'd1;
        end
      end
      ST_RESP: begin
        w_cpu_ready_n = 1'b1;
        w_state_n     = ST_IDLE;
        if (r_err) begin
          w_cpu_rdata_n = ERR_RDATA;
        end else begin
          case (r_target)
            TGT_RAM:  w_cpu_rdata_n = w_ram_rdata;
            TGT_STAT: w_cpu_rdata_n = r_addr[2] ? {15'd0, r_irq, r_err_cnt} : r_err_addr;
            default:  w_cpu_rdata_n = r_rdata;
          endcase
        end
      end
      default: w_state_n = ST_IDLE;
    endcase

    // Target-facing address/data are zero whenever no request is driven.
    w_rom_addr_n  = w_rom_valid_n ? w_addr_n : '0;
    w_slv_addr_n  = (|w_slv_valid_n) ? w_addr_n : '0;
    w_slv_wdata_n = (|w_slv_valid_n) ? w_wdata_n : '0;
    w_slv_wstrb_n = (|w_slv_valid_n) ? w_wstrb_n : '0;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_n;
  end

  // Latched request, watchdog, status and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_target    <= TGT_RAM;
      r_idx       <= '0;
      r_err       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_cpu_ready <= 1'b0;
      r_cpu_rdata <= '0;
      r_rom_valid <= 1'b0;
      r_rom_addr  <= '0;
      r_slv_valid <= '0;
      r_slv_addr  <= '0;
      r_slv_wdata <= '0;
      r_slv_wstrb <= '0;
      r_err_addr  <= '0;
      r_err_cnt   <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_target    <= w_target_n;
      r_idx       <= w_idx_n;
      r_err       <= w_err_n;
      r_addr      <= w_addr_n;
      r_wdata     <= w_wdata_n;
      r_wstrb     <= w_wstrb_n;
      r_cnt       <= w_cnt_n;
      r_rdata     <= w_rdata_n;
      r_cpu_ready <= w_cpu_ready_n;
      r_cpu_rdata <= w_cpu_rdata_n;
      r_rom_valid <= w_rom_valid_n;
      r_rom_addr  <= w_rom_addr_n;
      r_slv_valid <= w_slv_valid_n;
      r_slv_addr  <= w_slv_addr_n;
      r_slv_wdata <= w_slv_wdata_n;
      r_slv_wstrb <= w_slv_wstrb_n;
      r_err_addr  <= w_err_addr_n;
      r_err_cnt   <= w_err_cnt_n;
      r_irq       <= w_irq_n;
    end
  end

  assign cpu_ready   = r_cpu_ready;
  assign cpu_rdata   = r_cpu_rdata;
  assign rom_valid   = r_rom_valid;
  assign rom_addr    = r_rom_addr;
  assign slv_valid   = r_slv_valid;
  assign slv_addr    = r_slv_addr;
  assign slv_wdata   = r_slv_wdata;
  assign slv_wstrb   = r_slv_wstrb;
  assign bus_err_irq = r_irq;

endmodule
